// File: rtl/dest_sequencer_if.sv
// Order-in / destination-out bundle of the destination sequencer.
// Ports:
//   rx_data, rx_valid   order byte and its one-cycle strobe
//   abort               synchronous flush of the current order
//   dest_x, dest_y      current destination coordinates
//   dest_valid          destination presented
//   dest_ready          planner accepts destination
//   dest_count          entries remaining, including the presented one
//   busy                sequencer is scanning or issuing
//   order_done          pulse after the last destination is accepted
//   order_empty         pulse when a completed order selects nothing
//   rx_drop             pulse when a byte arrives while busy
interface dest_sequencer_if #(
   parameter int unsigned N_LOC   = 6,
   parameter int unsigned COORD_W = 8
);
   localparam int unsigned CNT_W = $clog2(N_LOC + 1);

   logic [7:0]         rx_data;
   logic               rx_valid;
   logic               abort;
   logic [COORD_W-1:0] dest_x;
   logic [COORD_W-1:0] dest_y;
   logic               dest_valid;
   logic               dest_ready;
   logic [CNT_W-1:0]   dest_count;
   logic               busy;
   logic               order_done;
   logic               order_empty;
   logic               rx_drop;

   // sequencer side
   modport master (
      input  rx_data, rx_valid, abort, dest_ready,
      output dest_x, dest_y, dest_valid, dest_count,
             busy, order_done, order_empty, rx_drop
   );

   // order source / path planner side
   modport slave (
      output rx_data, rx_valid, abort, dest_ready,
      input  dest_x, dest_y, dest_valid, dest_count,
             busy, order_done, order_empty, rx_drop
   );
endinterface

// File: rtl/dest_sequencer.sv
// Destination sequencer: gathers order bits from UART bytes into a shelf
// mask, scans it MSB-first, buffers the coordinates of every selected shelf
// and hands them to the AGV path planner over valid/ready.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   dest_sequencer_if.master (order bytes in, destinations/status out)
module dest_sequencer #(
   parameter int unsigned N_LOC   = 6,
   parameter int unsigned COORD_W = 8,
   parameter logic [N_LOC*2*COORD_W-1:0] LOC_TABLE = 96'h3006_3022_3052_9056_9082_90a6
) (
   input  logic             clk,
   input  logic             rst,
   dest_sequencer_if.master bus
);
   localparam int unsigned NBYTES  = N_LOC / 2;
   localparam int unsigned CNT_W   = $clog2(N_LOC + 1);
   localparam int unsigned ENTRY_W = 2 * COORD_W;
   localparam int unsigned BCNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   localparam logic [1:0] S_COLLECT = 2'd0;
   localparam logic [1:0] S_SCAN    = 2'd1;
   localparam logic [1:0] S_ISSUE   = 2'd2;

   logic [1:0]         state, state_nxt;
   logic [N_LOC-1:0]   mask, mask_nxt;
   logic [BCNT_W-1:0]  bcnt, bcnt_nxt;
   logic [CNT_W-1:0]   idx, idx_nxt;
   logic [CNT_W-1:0]   wr_ptr, wr_nxt;
   logic [CNT_W-1:0]   rd_ptr, rd_nxt;
   logic [CNT_W-1:0]   count, count_nxt;
   logic [ENTRY_W-1:0] list [N_LOC];
   logic [ENTRY_W-1:0] list_nxt [N_LOC];

   logic               scan_bit;
   logic [ENTRY_W-1:0] scan_entry;
   logic [ENTRY_W-1:0] head_entry;

   logic               valid_q, valid_nxt;
   logic [COORD_W-1:0] x_q, x_nxt, y_q, y_nxt;
   logic [CNT_W-1:0]   dcnt_q, dcnt_nxt;
   logic               busy_q, busy_nxt;
   logic               done_q, done_nxt;
   logic               empty_q, empty_nxt;
   logic               drop_q, drop_nxt;

   // only bits 4 and 0 of each byte carry order information
   logic unused_rx_bits;
   assign unused_rx_bits = ^{bus.rx_data[7:5], bus.rx_data[3:1]};

   // state and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_COLLECT;
         mask    <= '0;
         bcnt    <= '0;
         idx     <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         for (int k = 0; k < N_LOC; k++) list[k] <= '0;
         valid_q <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         dcnt_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         empty_q <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         mask    <= mask_nxt;
         bcnt    <= bcnt_nxt;
         idx     <= idx_nxt;
         wr_ptr  <= wr_nxt;
         rd_ptr  <= rd_nxt;
         count   <= count_nxt;
         list    <= list_nxt;
         valid_q <= valid_nxt;
         x_q     <= x_nxt;
         y_q     <= y_nxt;
         dcnt_q  <= dcnt_nxt;
         busy_q  <= busy_nxt;
         done_q  <= done_nxt;
         empty_q <= empty_nxt;
         drop_q  <= drop_nxt;
      end
   end

   // next-state and next-output logic
   always_comb begin
      state_nxt = state;
      mask_nxt  = mask;
      bcnt_nxt  = bcnt;
      idx_nxt   = idx;
      wr_nxt    = wr_ptr;
      rd_nxt    = rd_ptr;
      count_nxt = count;
      list_nxt  = list;
      done_nxt  = 1'b0;
      empty_nxt = 1'b0;
      drop_nxt  = 1'b0;

      // mask bit and table entry under the scan index
      scan_bit   = 1'b0;
      scan_entry = '0;
      for (int k = 0; k < N_LOC; k++) begin
         if (idx == CNT_W'(k)) begin
            scan_bit   = mask[k];
            scan_entry = LOC_TABLE[k*ENTRY_W +: ENTRY_W];
         end
      end

      if (bus.abort) begin
         // flush wins over everything; a same-cycle byte vanishes silently
         state_nxt = S_COLLECT;
         mask_nxt  = '0;
         bcnt_nxt  = '0;
         idx_nxt   = '0;
         wr_nxt    = '0;
         rd_nxt    = '0;
         count_nxt = '0;
      end else begin
         drop_nxt = bus.rx_valid && (state != S_COLLECT);
         case (state)
            S_COLLECT: begin
               if (bus.rx_valid) begin
                  for (int b = 0; b < NBYTES; b++) begin
                     if (bcnt == BCNT_W'(b)) begin
                        mask_nxt[N_LOC-1-2*b] = bus.rx_data[4];
                        mask_nxt[N_LOC-2-2*b] = bus.rx_data[0];
                     end
                  end
                  if (bcnt == BCNT_W'(NBYTES - 1)) begin
                     bcnt_nxt  = '0;
                     state_nxt = S_SCAN;
                     idx_nxt   = CNT_W'(N_LOC - 1);
                  end else begin
                     bcnt_nxt = bcnt + BCNT_W'(1);
                  end
               end
            end
            S_SCAN: begin
               if (scan_bit) begin
                  for (int j = 0; j < N_LOC; j++)
                     if (wr_ptr == CNT_W'(j)) list_nxt[j] = scan_entry;
                  wr_nxt    = wr_ptr + CNT_W'(1);
                  count_nxt = count + CNT_W'(1);
               end
               if (idx == '0) begin
                  if (count_nxt == '0) begin
                     empty_nxt = 1'b1;
                     state_nxt = S_COLLECT;
                     mask_nxt  = '0;
                  end else begin
                     state_nxt = S_ISSUE;
                     rd_nxt    = '0;
                  end
               end else begin
                  idx_nxt = idx - CNT_W'(1);
               end
            end
            S_ISSUE: begin
               if (valid_q && bus.dest_ready) begin
                  if (rd_ptr + CNT_W'(1) == count) begin
                     done_nxt  = 1'b1;
                     state_nxt = S_COLLECT;
                     mask_nxt  = '0;
                     wr_nxt    = '0;
                     rd_nxt    = '0;
                     count_nxt = '0;
                  end else begin
                     rd_nxt = rd_ptr + CNT_W'(1);
                  end
               end
            end
            default: state_nxt = S_COLLECT;
         endcase
      end

      // outputs follow the next state so they line up with it after the edge
      head_entry = '0;
      for (int k = 0; k < N_LOC; k++)
         if (rd_nxt == CNT_W'(k)) head_entry = list_nxt[k];

      valid_nxt = (state_nxt == S_ISSUE);
      x_nxt     = valid_nxt ? head_entry[COORD_W-1:0] : '0;
      y_nxt     = valid_nxt ? head_entry[ENTRY_W-1:COORD_W] : '0;
      dcnt_nxt  = valid_nxt ? (count_nxt - rd_nxt) : '0;
      busy_nxt  = (state_nxt != S_COLLECT);
   end

   assign bus.dest_valid  = valid_q;
   assign bus.dest_x      = x_q;
   assign bus.dest_y      = y_q;
   assign bus.dest_count  = dcnt_q;
   assign bus.busy        = busy_q;
   assign bus.order_done  = done_q;
   assign bus.order_empty = empty_q;
   assign bus.rx_drop     = drop_q;
endmodule

// File: tb/tb_dest_sequencer.sv
// Bench for dest_sequencer: two instances (default 6-location and a 4-location
// variant) share one stimulus stream; an order-level model predicts every
// output each cycle, and directed scenarios pin the model with literal values.
module tb_dest_sequencer;
   localparam logic [95:0] TBL0 = 96'h3006_3022_3052_9056_9082_90a6;
   localparam logic [31:0] TBL1 = 32'h1234_5678;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       abort;
   logic       ready;

   always #5 clk = ~clk;

   dest_sequencer_if #(.N_LOC(6), .COORD_W(8)) if0 ();
   dest_sequencer_if #(.N_LOC(4), .COORD_W(4)) if1 ();

   assign if0.rx_data    = rx_data;
   assign if0.rx_valid   = rx_valid;
   assign if0.abort      = abort;
   assign if0.dest_ready = ready;
   assign if1.rx_data    = rx_data;
   assign if1.rx_valid   = rx_valid;
   assign if1.abort      = abort;
   assign if1.dest_ready = ready;

   dest_sequencer #(.N_LOC(6), .COORD_W(8), .LOC_TABLE(TBL0)) dut0 (.clk(clk), .rst(rst), .bus(if0.master));
   dest_sequencer #(.N_LOC(4), .COORD_W(4), .LOC_TABLE(TBL1)) dut1 (.clk(clk), .rst(rst), .bus(if1.master));

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- order-level reference model ----------------
   int          nl [2];
   int          cw [2];
   int          ph [2];        // 0 gathering bytes, 1 scanning, 2 issuing
   int          nb [2];
   int          scan_left [2];
   int          head [2];
   int          tail [2];
   logic [15:0] mmask [2];
   logic [15:0] lst [2][16];
   int          e_done [2];
   int          e_empty [2];
   int          e_drop [2];

   initial begin
      nl[0] = 6; cw[0] = 8;
      nl[1] = 4; cw[1] = 4;
   end

   function automatic logic [15:0] entry(input int d, input int k);
      logic [95:0] t0;
      logic [31:0] t1;
      t0 = TBL0 >> (k * 16);
      t1 = TBL1 >> (k * 8);
      if (d == 0) return t0[15:0];
      return {8'h00, t1[7:0]};
   endfunction

   task automatic model_step(input int d);
      int was;
      was = ph[d];
      e_done[d] = 0; e_empty[d] = 0; e_drop[d] = 0;
      if (rst || abort) begin
         ph[d] = 0; nb[d] = 0; mmask[d] = '0; head[d] = 0; tail[d] = 0;
         return;
      end
      if (rx_valid && was != 0) e_drop[d] = 1;
      case (was)
         0: if (rx_valid) begin
               mmask[d][nl[d]-1-2*nb[d]] = rx_data[4];
               mmask[d][nl[d]-2-2*nb[d]] = rx_data[0];
               nb[d]++;
               if (nb[d] == nl[d] / 2) begin
                  nb[d] = 0; ph[d] = 1; scan_left[d] = nl[d];
                  head[d] = 0; tail[d] = 0;
                  for (int k = nl[d] - 1; k >= 0; k--)
                     if (mmask[d][k]) begin lst[d][tail[d]] = entry(d, k); tail[d]++; end
               end
            end
         1: begin
               scan_left[d]--;
               if (scan_left[d] == 0) begin
                  if (tail[d] == 0) begin e_empty[d] = 1; ph[d] = 0; mmask[d] = '0; end
                  else ph[d] = 2;
               end
            end
         default: if (ready) begin
               head[d]++;
               if (head[d] == tail[d]) begin
                  e_done[d] = 1; ph[d] = 0; mmask[d] = '0; head[d] = 0; tail[d] = 0;
               end
            end
      endcase
   endtask

   always @(posedge clk) begin
      cyc++;
      model_step(0);
      model_step(1);
   end

   // ---------------- compare / record process ----------------
   int a_v [2], a_x [2], a_y [2], a_c [2], a_b [2], a_d [2], a_e [2], a_r [2];
   int log_n [2], log_xy [2][32], log_cnt [2][32], log_cyc [2][32];
   int done_n [2], empty_n [2], drop_n [2], busy_n [2], scan_n [2], valid_n [2];
   int stall22_n;

   task automatic clear_logs();
      for (int d = 0; d < 2; d++) begin
         log_n[d] = 0; done_n[d] = 0; empty_n[d] = 0; drop_n[d] = 0;
         busy_n[d] = 0; scan_n[d] = 0; valid_n[d] = 0;
      end
      stall22_n = 0;
   endtask

   always begin
      int ev, ex, ey, ec, eb;
      logic [15:0] e;
      @(negedge clk);
      #4;
      a_v[0] = int'(if0.dest_valid); a_x[0] = int'(if0.dest_x); a_y[0] = int'(if0.dest_y);
      a_c[0] = int'(if0.dest_count); a_b[0] = int'(if0.busy);  a_d[0] = int'(if0.order_done);
      a_e[0] = int'(if0.order_empty); a_r[0] = int'(if0.rx_drop);
      a_v[1] = int'(if1.dest_valid); a_x[1] = int'(if1.dest_x); a_y[1] = int'(if1.dest_y);
      a_c[1] = int'(if1.dest_count); a_b[1] = int'(if1.busy);  a_d[1] = int'(if1.order_done);
      a_e[1] = int'(if1.order_empty); a_r[1] = int'(if1.rx_drop);
      for (int d = 0; d < 2; d++) begin
         ev = 0; ex = 0; ey = 0; ec = 0; eb = 0;
         if (!rst && ph[d] == 2) begin
            ev = 1;
            e  = lst[d][head[d]];
            ex = int'(e) & ((1 << cw[d]) - 1);
            ey = (int'(e) >> cw[d]) & ((1 << cw[d]) - 1);
            ec = tail[d] - head[d];
         end
         if (!rst && ph[d] != 0) eb = 1;
         chk($sformatf("dest_valid[%0d]", d), a_v[d], ev);
         chk($sformatf("dest_x[%0d]", d), a_x[d], ex);
         chk($sformatf("dest_y[%0d]", d), a_y[d], ey);
         chk($sformatf("dest_count[%0d]", d), a_c[d], ec);
         chk($sformatf("busy[%0d]", d), a_b[d], eb);
         chk($sformatf("order_done[%0d]", d), a_d[d], rst ? 0 : e_done[d]);
         chk($sformatf("order_empty[%0d]", d), a_e[d], rst ? 0 : e_empty[d]);
         chk($sformatf("rx_drop[%0d]", d), a_r[d], rst ? 0 : e_drop[d]);
         if (!rst) begin
            if (a_v[d] != 0 && ready && log_n[d] < 32) begin
               log_xy[d][log_n[d]]  = (a_y[d] << cw[d]) | a_x[d];
               log_cnt[d][log_n[d]] = a_c[d];
               log_cyc[d][log_n[d]] = cyc;
               log_n[d]++;
            end
            if (d == 0 && a_v[0] != 0 && !ready && a_x[0] == 'h22 && a_y[0] == 'h30) stall22_n++;
            done_n[d]  += a_d[d];
            empty_n[d] += a_e[d];
            drop_n[d]  += a_r[d];
            busy_n[d]  += a_b[d];
            valid_n[d] += a_v[d];
            if (a_b[d] != 0 && a_v[d] == 0) scan_n[d]++;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((if0.busy || if1.busy) && n < 300) begin tick(); n++; end
      chk("wait_idle", int'(if0.busy | if1.busy), 0);
      repeat (3) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; rx_data = '0; rx_valid = 1'b0; abort = 1'b0; ready = 1'b1;
      clear_logs();
      repeat (3) tick();
      chk("reset_valid", int'(if0.dest_valid), 0);
      chk("reset_busy", int'(if0.busy), 0);
      chk("reset_count", int'(if0.dest_count), 0);
      chk("reset_x", int'(if0.dest_x), 0);
      chk("reset_busy1", int'(if1.busy), 0);
      rst = 1'b0;
      tick();

      // mask 110001, ready held high
      clear_logs();
      send(8'h11); send(8'h00); send(8'h01);
      wait_idle();
      chk("t1_beats", log_n[0], 3);
      chk("t1_beat0", log_xy[0][0], 'h3006);
      chk("t1_beat1", log_xy[0][1], 'h3022);
      chk("t1_beat2", log_xy[0][2], 'h90a6);
      chk("t1_cnt0", log_cnt[0][0], 3);
      chk("t1_cnt1", log_cnt[0][1], 2);
      chk("t1_cnt2", log_cnt[0][2], 1);
      chk("t1_consecutive", log_cyc[0][2] - log_cyc[0][0], 2);
      chk("t1_done", done_n[0], 1);
      chk("t1_scan_cycles", scan_n[0], 6);

      // full mask with a 5-cycle stall on the second beat
      clear_logs();
      send(8'h11); send(8'h11); send(8'h11);
      n = 0;
      while (!(if0.dest_valid && if0.dest_count == 3'd5) && n < 100) begin tick(); n++; end
      chk("t2_reach_beat2", int'(if0.dest_count), 5);
      ready = 1'b0;
      repeat (5) tick();
      ready = 1'b1;
      wait_idle();
      chk("t2_beats", log_n[0], 6);
      chk("t2_beat0", log_xy[0][0], 'h3006);
      chk("t2_beat1", log_xy[0][1], 'h3022);
      chk("t2_beat2", log_xy[0][2], 'h3052);
      chk("t2_beat3", log_xy[0][3], 'h9056);
      chk("t2_beat4", log_xy[0][4], 'h9082);
      chk("t2_beat5", log_xy[0][5], 'h90a6);
      chk("t2_stall_hold", stall22_n, 5);
      chk("t2_done", done_n[0], 1);

      // all-zero order
      clear_logs();
      send(8'h00); send(8'h00); send(8'h00);
      wait_idle();
      chk("t3_empty", empty_n[0], 1);
      chk("t3_no_valid", valid_n[0], 0);
      chk("t3_busy_cycles", busy_n[0], 6);
      chk("t3_no_done", done_n[0], 0);

      // byte dropped while issuing, then abort mid-issue
      clear_logs();
      ready = 1'b0;
      send(8'h11); send(8'h11); send(8'h11);
      n = 0;
      while (!if0.dest_valid && n < 100) begin tick(); n++; end
      chk("t4_valid_seen", int'(if0.dest_valid), 1);
      send(8'hff);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      repeat (2) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t4_abort_valid", int'(if0.dest_valid), 0);
      chk("t4_abort_busy", int'(if0.busy), 0);
      repeat (2) tick();
      chk("t4_drop", drop_n[0], 1);
      chk("t4_beats", log_n[0], 1);
      chk("t4_beat0", log_xy[0][0], 'h3006);
      chk("t4_no_done", done_n[0], 0);
      clear_logs();
      ready = 1'b1;
      send(8'h10); send(8'h00); send(8'h00);
      wait_idle();
      chk("t4b_beats", log_n[0], 1);
      chk("t4b_beat0", log_xy[0][0], 'h3006);
      chk("t4b_done", done_n[0], 1);

      // 4-location instance: mask 0110
      abort = 1'b1; tick(); abort = 1'b0;
      clear_logs();
      send(8'h01); send(8'h10);
      wait_idle();
      chk("t5_beats", log_n[1], 2);
      chk("t5_beat0", log_xy[1][0], 'h34);
      chk("t5_beat1", log_xy[1][1], 'h56);
      chk("t5_scan_cycles", scan_n[1], 4);
      chk("t5_done", done_n[1], 1);
      abort = 1'b1; tick(); abort = 1'b0;

      // asynchronous reset in the middle of a scan
      clear_logs();
      send(8'h11); send(8'h11); send(8'h11);
      tick();
      rst = 1'b1;
      #1;
      chk("t6_rst_valid", int'(if0.dest_valid), 0);
      chk("t6_rst_busy", int'(if0.busy), 0);
      chk("t6_rst_done", int'(if0.order_done), 0);
      repeat (2) tick();
      rst = 1'b0;
      tick();
      clear_logs();
      send(8'h11); send(8'h00); send(8'h01);
      wait_idle();
      chk("t6_beats", log_n[0], 3);
      chk("t6_beat2", log_xy[0][2], 'h90a6);
      chk("t6_done", done_n[0], 1);

      // randomized traffic, model-checked every cycle
      for (int i = 0; i < 3000; i++) begin
         ready    = ($urandom_range(0, 3) != 0);
         rx_valid = ($urandom_range(0, 2) == 0);
         rx_data  = 8'($urandom);
         abort    = ($urandom_range(0, 79) == 0);
         rst      = ($urandom_range(0, 499) == 0);
         tick();
      end
      rst = 1'b0; abort = 1'b0; rx_valid = 1'b0; ready = 1'b1;
      wait_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/dest_sequencer.md
Name: dest_sequencer

Overview:
- Parametrised successor to the order-to-destination mapper that feeds the AGV path planner.
- Collects order bits from received UART bytes into an N_LOC-bit shelf mask, then scans the mask MSB-first.
- Buffers the coordinate pair of every selected shelf and issues them one at a time over a valid/ready handshake.
- Adds over the previous mapper: explicit byte strobe, configurable location table, backpressure, completion/empty flags, abort, and a reset.

Parameters:
- N_LOC, 6, number of shelf locations; must be even, 2..16.
- COORD_W, 8, width of each x and y coordinate.
- LOC_TABLE, 96'h3006_3022_3052_9056_9082_90a6, flat N_LOC*2*COORD_W table.
  - Entry k = LOC_TABLE[k*2*COORD_W +: 2*COORD_W] = {y,x} for mask bit k.
- Localparams: NBYTES = N_LOC/2; CNT_W = $clog2(N_LOC+1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  received order byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- abort  in  1  synchronous flush of current order.
- dest_x  out  COORD_W  x coordinate of current destination.
- dest_y  out  COORD_W  y coordinate of current destination.
- dest_valid  out  1  destination presented.
- dest_ready  in  1  planner accepts destination.
- dest_count  out  CNT_W  entries remaining, including the one presented.
- busy  out  1  high in SCAN or ISSUE.
- order_done  out  1  one-cycle pulse after the last destination is accepted.
- order_empty  out  1  one-cycle pulse when a completed mask is all zero.
- rx_drop  out  1  one-cycle pulse when rx_valid arrives outside COLLECT.

Behaviour:
- Reset: state COLLECT; mask, byte counter, list, wr/rd pointers and count cleared; all outputs 0.
- COLLECT:
  - Each rx_valid byte writes rx_data[4] to mask[N_LOC-1-2b] and rx_data[0] to mask[N_LOC-2-2b], where b is the byte counter (0..NBYTES-1).
  - On the byte with b = NBYTES-1 (edge E): byte counter clears and state becomes SCAN with index N_LOC-1.
- SCAN:
  - One mask bit per cycle, index N_LOC-1 down to 0; bit k is examined at edge E+1+(N_LOC-1-k).
  - If the bit is set, LOC_TABLE entry k is written to list[wr_ptr], then wr_ptr and count increment.
  - Result: the list order equals the MSB-first mask order.
  - After index 0 (edge E+N_LOC):
    - count = 0: pulse order_empty, go to COLLECT, clear mask.
    - Otherwise: go to ISSUE with rd_ptr = 0.
- ISSUE:
  - dest_valid = 1; {dest_y,dest_x} = list[rd_ptr]; dest_count = count - rd_ptr.
  - While dest_ready = 0, outputs are held stable.
  - On an edge with dest_valid & dest_ready, rd_ptr increments.
  - If that handshake was the last entry: next cycle dest_valid = 0, order_done = 1, state COLLECT, mask/pointers/count cleared.
  - A ready-high stream gives one destination per cycle.
- dest_x, dest_y and dest_count are 0 whenever dest_valid = 0.
- busy = (state != COLLECT).
- rx_valid in SCAN/ISSUE: byte discarded, rx_drop pulses next cycle, mask unaffected.
- abort:
  - Highest priority after rst, in any state.
  - Next cycle: COLLECT, mask, byte counter, pointers and count cleared, dest_valid = 0.
  - No order_done. A rx_valid in the same cycle as abort is discarded without rx_drop.
- Partial order in COLLECT persists indefinitely until completed, aborted or reset.
- Async rst mid-SCAN/ISSUE: immediate return to reset values; no pulses are generated.
- Width rules:
  - Pointers and count are CNT_W bits; count never exceeds N_LOC.
  - Location table indices are static, no arithmetic on coordinates.

Test Plan:
- Reset with rst high mid-stream -> all outputs 0, busy 0; the next full order is processed normally.
- Default params, bytes 0x11, 0x00, 0x01 with ready high -> mask 110001.
  - SCAN lasts 6 cycles.
  - Beats (x,y): (0x06,0x30), (0x22,0x30), (0xA6,0x90) on consecutive cycles.
  - dest_count goes 3, 2, 1; order_done pulses once after the third beat.
- Bytes 0x11, 0x11, 0x11 with dest_ready low 5 cycles at the 2nd beat -> 6 beats in table order 06, 22, 52, 56, 82, A6.
  - Beat 2 = (0x22,0x30) is held stable for all 5 stall cycles.
- Bytes 0x00 x3 -> order_empty pulse at E+6; dest_valid never asserts; busy high for exactly 6 cycles.
- rx_valid 0xFF during ISSUE -> rx_drop pulse, issued list unchanged.
  - abort mid-ISSUE -> dest_valid 0 next cycle, no order_done.
  - Following bytes 0x10, 0x00, 0x00 -> single beat (0x06,0x30).
- N_LOC=4, COORD_W=4, LOC_TABLE=32'h1234_5678 with bytes 0x01, 0x10 -> mask 0110.
  - Beats {y,x} = 0x34 then 0x56, i.e. (x=4,y=3) then (x=6,y=5); SCAN lasts 4 cycles.
